// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned NUM_PORTS      = 2;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef logic [0:0] port_id_t;

    function automatic port_id_t other_port(port_id_t p);
        return port_id_t'(~p);
    endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational one-hot grant selection for the data-memory arbiter.
// Round-robin among valid ports when DMEM_ARB_RR_EN is defined, else port 0 has fixed priority.
module dmem_arb_grant
    import dmem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid,
`ifdef DMEM_ARB_RR_EN
    input  port_id_t             ptr,
`endif
    input  arb_state_e           state,
    output logic [NUM_PORTS-1:0] grant_c
);

    always_comb begin
        grant_c = '0;
        case (state)
            LOCK0:   grant_c[0] = valid[0];
            LOCK1:   grant_c[1] = valid[1];
            default: begin
`ifdef DMEM_ARB_RR_EN
                // Contention goes to the pointer port; otherwise the lone requester wins.
                if (&valid) begin
                    grant_c[ptr] = 1'b1;
                end else begin
                    grant_c = valid;
                end
`else
                grant_c[0] = valid[0];
                grant_c[1] = valid[1] & ~valid[0];
`endif
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory with lock ownership.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (port 0 first).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic                  p0_req_lock,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic                  p1_req_lock,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,

    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] data_out
);

    arb_state_e           state_q, state_d;
    logic                 rsp_vld_q, rsp_vld_d;
    port_id_t             rsp_port_q, rsp_port_d;
    logic                 rsp_rd_q, rsp_rd_d;
    logic [NUM_PORTS-1:0] valid_c;
    logic [NUM_PORTS-1:0] grant_c;
    logic [NUM_PORTS-1:0] acc_c;
    logic                 rsp_live_c;
`ifdef DMEM_ARB_RR_EN
    port_id_t             ptr_q, ptr_d;
`endif

    assign valid_c = {p1_req_valid, p0_req_valid};

    dmem_arb_grant u_grant (
        .valid   (valid_c),
`ifdef DMEM_ARB_RR_EN
        .ptr     (ptr_q),
`endif
        .state   (state_q),
        .grant_c (grant_c)
    );

    // Nothing is accepted while reset is held, so no stray memory write can slip through.
    assign acc_c        = grant_c & {NUM_PORTS{~rstn}};
    assign p0_req_ready = acc_c[0];
    assign p1_req_ready = acc_c[1];

    // Next state, ownership and response tracking.
    always_comb begin
        state_d    = state_q;
        rsp_vld_d  = 1'b0;
        rsp_port_d = port_id_t'(0);
        rsp_rd_d   = 1'b0;
`ifdef DMEM_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        if (acc_c[0]) begin
            state_d    = p0_req_lock ? LOCK0 : ARB;
            rsp_vld_d  = 1'b1;
            rsp_port_d = port_id_t'(0);
            rsp_rd_d   = ~p0_req_we;
`ifdef DMEM_ARB_RR_EN
            ptr_d      = other_port(port_id_t'(0));
`endif
        end else if (acc_c[1]) begin
            state_d    = p1_req_lock ? LOCK1 : ARB;
            rsp_vld_d  = 1'b1;
            rsp_port_d = port_id_t'(1);
            rsp_rd_d   = ~p1_req_we;
`ifdef DMEM_ARB_RR_EN
            ptr_d      = other_port(port_id_t'(1));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= ARB;
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= port_id_t'(0);
            rsp_rd_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            ptr_q      <= port_id_t'(0);
`endif
        end else begin
            state_q    <= state_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_port_q <= rsp_port_d;
            rsp_rd_q   <= rsp_rd_d;
`ifdef DMEM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Memory-side mux of the granted request.
    always_comb begin
        addr    = '0;
        data_in = '0;
        wrEn    = 1'b0;
        if (acc_c[0]) begin
            addr    = p0_req_addr;
            data_in = p0_req_wdata;
            wrEn    = p0_req_we;
        end else if (acc_c[1]) begin
            addr    = p1_req_addr;
            data_in = p1_req_wdata;
            wrEn    = p1_req_we;
        end
    end

    // A response in flight when reset asserts is dropped.
    assign rsp_live_c   = rsp_vld_q & ~rstn;
    assign p0_rsp_valid = rsp_live_c & (rsp_port_q == port_id_t'(0));
    assign p1_rsp_valid = rsp_live_c & (rsp_port_q == port_id_t'(1));
    assign p0_rsp_rdata = (p0_rsp_valid & rsp_rd_q) ? data_out : '0;
    assign p1_rsp_rdata = (p1_rsp_valid & rsp_rd_q) ? data_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
// Contention expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW = DEF_ADDR_WIDTH;
    localparam int unsigned DW = DEF_DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rstn;
    logic          p0_req_valid, p0_req_ready, p0_req_we, p0_req_lock;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata;
    logic          p0_rsp_valid;
    logic [DW-1:0] p0_rsp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_we, p1_req_lock;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata;
    logic          p1_rsp_valid;
    logic [DW-1:0] p1_rsp_rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic          wrEn;
    logic [DW-1:0] data_out;

    logic [DW-1:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_req_we    (p0_req_we),
        .p0_req_lock  (p0_req_lock),
        .p0_req_addr  (p0_req_addr),
        .p0_req_wdata (p0_req_wdata),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_req_we    (p1_req_we),
        .p1_req_lock  (p1_req_lock),
        .p1_req_addr  (p1_req_addr),
        .p1_req_wdata (p1_req_wdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_rdata (p1_rsp_rdata),
        .addr         (addr),
        .data_in      (data_in),
        .wrEn         (wrEn),
        .data_out     (data_out)
    );

    // Synchronous memory: write on grant, read data one cycle after the address.
    always @(posedge clk) begin
        if (wrEn) mem[addr[7:0]] <= data_in;
        data_out <= mem[addr[7:0]];
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_all();
        p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_lock = 1'b0;
        p0_req_addr  = '0;   p0_req_wdata = '0;
        p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_lock = 1'b0;
        p1_req_addr  = '0;   p1_req_wdata = '0;
    endtask

    task automatic drive_p0(input logic v, input logic we, input logic lk,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_req_valid = v; p0_req_we = we; p0_req_lock = lk; p0_req_addr = a; p0_req_wdata = d;
    endtask

    task automatic drive_p1(input logic v, input logic we, input logic lk,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_req_valid = v; p1_req_we = we; p1_req_lock = lk; p1_req_addr = a; p1_req_wdata = d;
    endtask

    // Advance to the next negedge; inputs set afterwards apply to the next rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_all();
        rstn = 1'b1;
        next_cycle();
        next_cycle();
        rstn = 1'b0;
    endtask

    logic exp0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'(0);
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h11] = 32'h1111_2222;
        mem[8'h20] = 32'h0000_A5A5;
        mem[8'h30] = 32'h3333_0000;

        // Reset: outputs held at zero even with a request pending.
        idle_all();
        rstn = 1'b1;
        next_cycle();
        drive_p0(1'b1, 1'b1, 1'b0, 32'h10, 32'h77);
        #1;
        chk("rst_p0_ready", DW'(p0_req_ready), DW'(0));
        chk("rst_wren",     DW'(wrEn),         DW'(0));
        chk("rst_addr",     DW'(addr),         DW'(0));
        chk("rst_data_in",  data_in,           DW'(0));
        next_cycle();
        #1;
        chk("rst_p0_rsp",   DW'(p0_rsp_valid), DW'(0));
        chk("rst_p0_rdata", p0_rsp_rdata,      DW'(0));
        do_reset();

        // Single read from p0.
        drive_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        chk("rd_p0_ready", DW'(p0_req_ready), DW'(1));
        chk("rd_p1_ready", DW'(p1_req_ready), DW'(0));
        chk("rd_addr",     DW'(addr),         DW'(32'h10));
        chk("rd_wren",     DW'(wrEn),         DW'(0));
        next_cycle();
        idle_all();
        #1;
        chk("rd_p0_rsp",   DW'(p0_rsp_valid), DW'(1));
        chk("rd_p0_rdata", p0_rsp_rdata,      32'hDEADBEEF);
        chk("rd_p1_rsp",   DW'(p1_rsp_valid), DW'(0));
        next_cycle();
        #1;
        chk("rd_p0_rsp_once", DW'(p0_rsp_valid), DW'(0));
        do_reset();

        // Contention for four cycles, then p0 drops.
        drive_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        drive_p1(1'b1, 1'b0, 1'b0, 32'h11, 32'h0);
        exp0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) p0_req_valid = 1'b0;
            #1;
            if (k > 0) begin
                chk($sformatf("ct_p0_rsp%0d", k), DW'(p0_rsp_valid), DW'(exp0));
                chk($sformatf("ct_p1_rsp%0d", k), DW'(p1_rsp_valid), DW'(!exp0));
                chk($sformatf("ct_rdata%0d", k), exp0 ? p0_rsp_rdata : p1_rsp_rdata,
                    exp0 ? 32'hDEADBEEF : 32'h1111_2222);
            end
`ifdef DMEM_ARB_RR_EN
            exp0 = (k % 2 == 0) && (k < 4);
`else
            exp0 = (k < 4);
`endif
            chk($sformatf("ct_p0_ready%0d", k), DW'(p0_req_ready), DW'(exp0));
            chk($sformatf("ct_p1_ready%0d", k), DW'(p1_req_ready), DW'(!exp0));
            next_cycle();
        end
        idle_all();
        #1;
        chk("ct_p1_rsp_last", DW'(p1_rsp_valid), DW'(1));
        chk("ct_p1_rdata_last", p1_rsp_rdata, 32'h1111_2222);
        do_reset();

        // Lock held by p1 across an idle gap while p0 keeps asking.
        drive_p1(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
        #1;
        chk("lk_p1_ready0", DW'(p1_req_ready), DW'(1));
        next_cycle();
        drive_p0(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        drive_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("lk_gap_p0_ready", DW'(p0_req_ready), DW'(0));
        chk("lk_gap_wren",     DW'(wrEn),         DW'(0));
        chk("lk_p1_rsp_rd",    DW'(p1_rsp_valid), DW'(1));
        chk("lk_p1_rdata",     p1_rsp_rdata,      32'h0000_A5A5);
        next_cycle();
        drive_p1(1'b1, 1'b1, 1'b0, 32'h20, 32'h5);
        #1;
        chk("lk_wr_p1_ready", DW'(p1_req_ready), DW'(1));
        chk("lk_wr_p0_ready", DW'(p0_req_ready), DW'(0));
        chk("lk_wr_wren",     DW'(wrEn),         DW'(1));
        chk("lk_wr_data_in",  data_in,           32'h5);
        chk("lk_wr_addr",     DW'(addr),         DW'(32'h20));
        next_cycle();
        drive_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("lk_rel_p0_ready", DW'(p0_req_ready), DW'(1));
        chk("lk_wr_p1_rsp",    DW'(p1_rsp_valid), DW'(1));
        chk("lk_wr_p1_rdata",  p1_rsp_rdata,      DW'(0));
        next_cycle();
        idle_all();
        #1;
        chk("lk_p0_rsp",   DW'(p0_rsp_valid), DW'(1));
        chk("lk_p0_rdata", p0_rsp_rdata,      32'h3333_0000);
        chk("lk_mem20",    mem[8'h20],        32'h5);
        do_reset();

        // Reset during LOCK0 right after an accepted read.
        drive_p0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
        next_cycle();
        drive_p0(1'b1, 1'b0, 1'b1, 32'h11, 32'h0);
        #1;
        chk("rm_lock_p0_ready", DW'(p0_req_ready), DW'(1));
        next_cycle();
        rstn = 1'b1;
        drive_p0(1'b1, 1'b1, 1'b1, 32'h40, 32'h99);
        #1;
        chk("rm_p0_rsp",   DW'(p0_rsp_valid), DW'(0));
        chk("rm_p0_rdata", p0_rsp_rdata,      DW'(0));
        chk("rm_wren",     DW'(wrEn),         DW'(0));
        chk("rm_p0_ready", DW'(p0_req_ready), DW'(0));
        next_cycle();
        rstn = 1'b0;
        idle_all();
        drive_p1(1'b1, 1'b0, 1'b0, 32'h11, 32'h0);
        #1;
        chk("rm_p1_ready",   DW'(p1_req_ready), DW'(1));
        chk("rm_p0_rsp_rel", DW'(p0_rsp_valid), DW'(0));
        next_cycle();
        idle_all();
        #1;
        chk("rm_p1_rsp",   DW'(p1_rsp_valid), DW'(1));
        chk("rm_mem40",    mem[8'h40],        DW'(0));

        // Back-to-back write then read of the same word.
        next_cycle();
        drive_p0(1'b1, 1'b1, 1'b0, 32'h4, 32'h1);
        #1;
        chk("bb_wr_ready",   DW'(p0_req_ready), DW'(1));
        chk("bb_wr_wren",    DW'(wrEn),         DW'(1));
        chk("bb_wr_data_in", data_in,           32'h1);
        next_cycle();
        drive_p0(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
        #1;
        chk("bb_rd_ready",  DW'(p0_req_ready), DW'(1));
        chk("bb_rd_wren",   DW'(wrEn),         DW'(0));
        chk("bb_wr_rsp",    DW'(p0_rsp_valid), DW'(1));
        chk("bb_wr_rdata",  p0_rsp_rdata,      DW'(0));
        next_cycle();
        idle_all();
        #1;
        chk("bb_rd_rsp",   DW'(p0_rsp_valid), DW'(1));
        chk("bb_rd_rdata", p0_rsp_rdata,      32'h1);
        next_cycle();
        #1;
        chk("bb_no_rsp", DW'(p0_rsp_valid), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
